// File: rtl/spi_flash_defs.sv
// Shared command codes and controller state encoding for the SPI flash responder.
package spi_flash_defs;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronisers for the SPI pins, plus single-cycle SCK rise/fall pulses.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sck_in,
  input  logic cs_in,
  input  logic mosi_in,
  output logic cs_n,
  output logic mosi,
  output logic sck_rise,
  output logic sck_fall
);

  logic [2:0] sck_q;
  logic [1:0] cs_q;
  logic [1:0] mosi_q;

  // CS resets to the deasserted level so the responder wakes up idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck_in};
      cs_q   <= {cs_q[0], cs_in};
      mosi_q <= {mosi_q[0], mosi_in};
    end
  end

  assign cs_n     = cs_q[1];
  assign mosi     = mosi_q[1];
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash emulator: READ / RDID / RDSR with a one-byte read prefetch.
//   state | meaning
//   IDLE  | CS high, or first cycle after CS falls; per-transaction state cleared
//   CMD   | shifting in the command byte
//   ADDR  | shifting in the 24-bit READ address, MSB first
//   DATA  | shifting response bytes out on MISO
module spi_flash_responder
  import spi_flash_defs::*;
#(
  parameter logic [23:0] JEDEC_ID   = 24'hEF4017,
  parameter logic [7:0]  STATUS_VAL = 8'h00,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spi_clk_i,
  input  logic        spi_cs_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_oe_o,
  output logic        mem_rd_o,
  output logic [23:0] mem_addr_o,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_valid_i,
  output logic [7:0]  cmd_o,
  output logic        busy_o,
  output logic        underrun_o
);

  logic       cs_n, mosi, sck_rise, sck_fall;
  state_t     state, state_d;
  logic [2:0] bit_cnt, out_cnt;
  logic [1:0] byte_cnt, out_idx;
  logic [7:0] sh_in, sh_out, pf_data, in_byte, nxt_byte, cur_byte;
  logic       byte_done, boundary, nxt_under, miss, resp, is_read;
  logic       first_byte, out_valid, pf_full, fetch_busy, late;

  spi_sync_edge u_sync (
    .clk      (clk_i),
    .rst      (rst_i),
    .sck_in   (spi_clk_i),
    .cs_in    (spi_cs_i),
    .mosi_in  (spi_mosi_i),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    in_byte   = {sh_in[6:0], mosi};
    byte_done = sck_rise && (bit_cnt == 3'd7);
    boundary  = sck_fall && (out_cnt == 3'd0);
    is_read   = (cmd_o == CMD_READ);
    nxt_byte  = FILL_BYTE;
    nxt_under = 1'b0;
    if (first_byte) begin
      if (out_valid) nxt_byte = sh_out;
      else           nxt_under = 1'b1;
    end else begin
      case (cmd_o)
        CMD_READ: if (pf_full) nxt_byte = pf_data; else nxt_under = 1'b1;
        CMD_RDID: if (out_idx == 2'd1)      nxt_byte = JEDEC_ID[15:8];
                  else if (out_idx == 2'd2) nxt_byte = JEDEC_ID[7:0];
        CMD_RDSR: nxt_byte = STATUS_VAL;
        default:  nxt_byte = FILL_BYTE;
      endcase
    end
    cur_byte = (out_cnt == 3'd0) ? nxt_byte : sh_out;
    miss     = boundary && nxt_under;
    resp     = mem_valid_i && fetch_busy;

    state_d = state;
    if (cs_n) state_d = IDLE;
    else begin
      case (state)
        IDLE:    state_d = CMD;
        CMD:     if (byte_done) state_d = (in_byte == CMD_READ) ? ADDR : DATA;
        ADDR:    if (byte_done && byte_cnt == 2'd2) state_d = DATA;
        default: state_d = state;
      endcase
    end
  end

  assign spi_miso_oe_o = (state == DATA) && !cs_n;
  assign busy_o        = !cs_n;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spi_miso_o <= 1'b1;
      mem_rd_o   <= 1'b0;
      mem_addr_o <= '0;
      cmd_o      <= '0;
      underrun_o <= 1'b0;
      bit_cnt    <= '0;
      out_cnt    <= '0;
      byte_cnt   <= '0;
      out_idx    <= '0;
      sh_in      <= '0;
      sh_out     <= '0;
      pf_data    <= '0;
      first_byte <= 1'b1;
      out_valid  <= 1'b0;
      pf_full    <= 1'b0;
      fetch_busy <= 1'b0;
      late       <= 1'b0;
    end else begin
      mem_rd_o <= 1'b0;
      if (sck_rise) begin
        sh_in   <= in_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (cs_n || state == IDLE) begin
        spi_miso_o <= 1'b1;
        bit_cnt    <= '0;
        out_cnt    <= '0;
        out_idx    <= '0;
        first_byte <= 1'b1;
        out_valid  <= 1'b0;
        pf_full    <= 1'b0;
        fetch_busy <= 1'b0;
        late       <= 1'b0;
        if (!cs_n) underrun_o <= 1'b0;
      end else begin
        case (state)
          CMD: if (byte_done) begin
            cmd_o    <= in_byte;
            byte_cnt <= '0;
            if (in_byte != CMD_READ) out_valid <= 1'b1;
            sh_out <= (in_byte == CMD_RDID) ? JEDEC_ID[23:16] :
                      (in_byte == CMD_RDSR) ? STATUS_VAL : FILL_BYTE;
          end
          ADDR: if (byte_done) begin
            mem_addr_o <= {mem_addr_o[15:0], in_byte};
            byte_cnt   <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd2) begin
              mem_rd_o   <= 1'b1;
              fetch_busy <= 1'b1;
            end
          end
          DATA: begin
            if (sck_fall) begin
              spi_miso_o <= cur_byte[7];
              sh_out     <= {cur_byte[6:0], 1'b0};
              out_cnt    <= out_cnt + 3'd1;
            end
            if (boundary) begin
              first_byte <= 1'b0;
              if (out_idx != 2'd3) out_idx <= out_idx + 2'd1;
              if (nxt_under && is_read) underrun_o <= 1'b1;
            end
            // A response whose byte slot already went out as fill is dropped; fetching moves on.
            if (is_read) begin
              if (resp) begin
                fetch_busy <= 1'b0;
                if (late || miss) begin
                  late       <= 1'b0;
                  mem_rd_o   <= 1'b1;
                  mem_addr_o <= mem_addr_o + 24'd1;
                  fetch_busy <= 1'b1;
                end else if (first_byte) begin
                  sh_out     <= mem_data_i;
                  out_valid  <= 1'b1;
                  mem_rd_o   <= 1'b1;
                  mem_addr_o <= mem_addr_o + 24'd1;
                  fetch_busy <= 1'b1;
                end else begin
                  pf_data <= mem_data_i;
                  pf_full <= 1'b1;
                end
              end else begin
                if (miss) late <= 1'b1;
                if (boundary && !first_byte && pf_full) begin
                  pf_full    <= 1'b0;
                  mem_rd_o   <= 1'b1;
                  mem_addr_o <= mem_addr_o + 24'd1;
                  fetch_busy <= 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
